// File: rtl/mux_pkg.sv
// Shared types and helpers for the sequenced multiplexer.
package mux_pkg;

  typedef enum logic {
    LOCK  = 1'b0,
    BLANK = 1'b1
  } state_e;

  // Select width for n channels; a single channel still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter that times the blanking interval of a select switch.
module blank_timer
  import mux_pkg::*;
#(
  parameter int unsigned BLANK_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_zero,
  output logic o_busy
);

  localparam int unsigned CW = clog2_min1(BLANK_CYC + 1);

  logic [CW-1:0] r_cnt;

  // Loading B-1 makes the switch complete exactly B edges after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(BLANK_CYC - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/seq_mux_n.sv
// Registered N-channel multiplexer that blanks its output for a fixed
// number of cycles whenever the selected channel changes.
module seq_mux_n
  import mux_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BLANK_CYC = 3,
  parameter int unsigned HOLD_MODE = 1,
  localparam int unsigned SELW     = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] i,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [SELW-1:0]    cur_sel,
  output logic               switch_done,
  output logic               sel_err
);

  localparam logic [SELW:0] L_N = (SELW + 1)'(N);

  state_e           r_state, w_nxt_state;
  logic [SELW-1:0]  r_cur, r_tgt, w_nxt_cur, w_nxt_tgt;
  logic [WIDTH-1:0] r_y, w_nxt_y;
  logic             r_valid, w_nxt_valid;
  logic             r_done, w_nxt_done;
  logic             r_sel_err;

  logic             w_sel_ok;
  logic [WIDTH-1:0] w_cur_data, w_sel_data, w_tgt_data, w_blank_y;
  logic             w_load, w_zero, w_busy;

  assign w_sel_ok   = ({1'b0, sel} < L_N);
  assign w_cur_data = i[int'(r_cur) * WIDTH +: WIDTH];
  assign w_sel_data = i[int'(sel)   * WIDTH +: WIDTH];
  assign w_tgt_data = i[int'(r_tgt) * WIDTH +: WIDTH];
  assign w_blank_y  = (HOLD_MODE != 0) ? r_y : '0;

  generate
    if (BLANK_CYC > 0) begin : g_timer
      blank_timer #(
        .BLANK_CYC(BLANK_CYC)
      ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_zero (w_zero),
        .o_busy (w_busy)
      );
    end else begin : g_no_timer
      logic w_unused_load;
      assign w_unused_load = w_load;
      assign w_zero        = 1'b1;
      assign w_busy        = 1'b0;
    end
  endgenerate

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cur   = r_cur;
    w_nxt_tgt   = r_tgt;
    w_nxt_y     = r_y;
    w_nxt_valid = r_valid;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      LOCK: begin
        if (w_sel_ok && (sel != r_cur)) begin
          if (BLANK_CYC == 0) begin
            w_nxt_cur   = sel;
            w_nxt_y     = w_sel_data;
            w_nxt_valid = 1'b1;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = BLANK;
            w_nxt_tgt   = sel;
            w_load      = 1'b1;
            w_nxt_valid = 1'b0;
            w_nxt_y     = w_blank_y;
          end
        end else begin
          w_nxt_y     = w_cur_data;
          w_nxt_valid = 1'b1;
        end
      end
      BLANK: begin
        // Any new valid request, even back to cur_sel, restarts the full blank.
        if (w_sel_ok && (sel != r_tgt)) begin
          w_nxt_tgt = sel;
          w_load    = 1'b1;
          w_nxt_y   = w_blank_y;
        end else if (w_busy) begin
          w_nxt_y = w_blank_y;
        end else if (w_zero) begin
          w_nxt_state = LOCK;
          w_nxt_cur   = r_tgt;
          w_nxt_y     = w_tgt_data;
          w_nxt_valid = 1'b1;
          w_nxt_done  = 1'b1;
        end
      end
      default: w_nxt_state = LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOCK;
      r_cur     <= '0;
      r_tgt     <= '0;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cur     <= w_nxt_cur;
      r_tgt     <= w_nxt_tgt;
      r_y       <= w_nxt_y;
      r_valid   <= w_nxt_valid;
      r_done    <= w_nxt_done;
      r_sel_err <= !w_sel_ok;
    end
  end

  assign y           = r_y;
  assign y_valid     = r_valid;
  assign cur_sel     = r_cur;
  assign switch_done = r_done;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_seq_mux_n.sv
// Bench for seq_mux_n: four configurations side by side, directed scenarios
// plus a randomized run against a deadline-based behavioural model.
module tb_seq_mux_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [31:0] i_a [4];
  logic [1:0]  sel_a [4];
  logic [7:0]  y_a [4];
  logic        yv_a [4], sd_a [4], se_a [4];
  logic [1:0]  cs_a [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance configuration: channel count, blank cycles, hold mode.
  int mN [4] = '{4, 4, 3, 4};
  int mB [4] = '{3, 3, 2, 0};
  int mH [4] = '{1, 0, 1, 1};

  always #5 clk = ~clk;

  seq_mux_n #(.N(4), .WIDTH(8), .BLANK_CYC(3), .HOLD_MODE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .i(i_a[0]), .sel(sel_a[0]), .y(y_a[0]),
    .y_valid(yv_a[0]), .cur_sel(cs_a[0]), .switch_done(sd_a[0]), .sel_err(se_a[0]));
  seq_mux_n #(.N(4), .WIDTH(8), .BLANK_CYC(3), .HOLD_MODE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i(i_a[1]), .sel(sel_a[1]), .y(y_a[1]),
    .y_valid(yv_a[1]), .cur_sel(cs_a[1]), .switch_done(sd_a[1]), .sel_err(se_a[1]));
  seq_mux_n #(.N(3), .WIDTH(8), .BLANK_CYC(2), .HOLD_MODE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i(i_a[2][23:0]), .sel(sel_a[2]), .y(y_a[2]),
    .y_valid(yv_a[2]), .cur_sel(cs_a[2]), .switch_done(sd_a[2]), .sel_err(se_a[2]));
  seq_mux_n #(.N(4), .WIDTH(8), .BLANK_CYC(0), .HOLD_MODE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .i(i_a[3]), .sel(sel_a[3]), .y(y_a[3]),
    .y_valid(yv_a[3]), .cur_sel(cs_a[3]), .switch_done(sd_a[3]), .sel_err(se_a[3]));

  // Behavioural model: a switch requested at edge e completes at edge e+B.
  bit         m_lock [4];
  int         m_cur [4], m_tgt [4], m_dl [4];
  logic [7:0] m_y [4];
  bit         m_v [4], m_done [4], m_err [4];
  int         cyc;

  function automatic logic [7:0] ch(input int k, input int c);
    logic [31:0] w;
    w = i_a[k];
    return w[c*8 +: 8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 4; k++) begin
        m_lock[k] = 1; m_cur[k] = 0; m_tgt[k] = 0; m_dl[k] = 0;
        m_y[k] = 8'h00; m_v[k] = 0; m_done[k] = 0; m_err[k] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        int s;
        bit ok;
        s  = int'(sel_a[k]);
        ok = (s < mN[k]);
        m_err[k]  = !ok;
        m_done[k] = 0;
        if (m_lock[k]) begin
          if (ok && s != m_cur[k]) begin
            if (mB[k] == 0) begin
              m_cur[k] = s; m_y[k] = ch(k, s); m_v[k] = 1; m_done[k] = 1;
            end else begin
              m_lock[k] = 0; m_tgt[k] = s; m_dl[k] = cyc + mB[k]; m_v[k] = 0;
              if (mH[k] == 0) m_y[k] = 8'h00;
            end
          end else begin
            m_y[k] = ch(k, m_cur[k]); m_v[k] = 1;
          end
        end else if (ok && s != m_tgt[k]) begin
          m_tgt[k] = s; m_dl[k] = cyc + mB[k];
        end else if (cyc == m_dl[k]) begin
          m_lock[k] = 1; m_cur[k] = m_tgt[k]; m_y[k] = ch(k, m_tgt[k]);
          m_v[k] = 1; m_done[k] = 1;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) sel_a[k] = 2'd0;
    i_a[0] = 32'h44332211; i_a[1] = 32'h44332211;
    i_a[2] = 32'h00CCBBAA; i_a[3] = 32'h44332211;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({y_a[k], yv_a[k], cs_a[k], sd_a[k], se_a[k]} !== 13'h0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h required 0", k,
                 {y_a[k], yv_a[k], cs_a[k], sd_a[k], se_a[k]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({y_a[0], yv_a[0]} !== {8'h11, 1'b1}) begin
      n_bad++;
      $display("FAIL first_edge: got y=%h v=%b required y=11 v=1", y_a[0], yv_a[0]);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({y_a[0], yv_a[0], sd_a[0]} !== 10'h0) begin
      n_bad++;
      $display("FAIL async_reset: got y=%h v=%b done=%b required 0", y_a[0], yv_a[0], sd_a[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_switch_hold();
    sel_a[0] = 2'd2;
    sel_a[1] = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({yv_a[0], yv_a[1], y_a[0], y_a[1], sd_a[0]} !== {2'b00, 8'h11, 8'h00, 1'b0}) begin
        n_bad++;
        $display("FAIL blank_cycle%0d: got v0=%b v1=%b y0=%h y1=%h d=%b required 0 0 11 00 0",
                 c, yv_a[0], yv_a[1], y_a[0], y_a[1], sd_a[0]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({y_a[k], yv_a[k], sd_a[k], cs_a[k]} !== {8'h33, 1'b1, 1'b1, 2'd2}) begin
        n_bad++;
        $display("FAIL switch_done[%0d]: got y=%h v=%b d=%b cs=%0d required 33 1 1 2",
                 k, y_a[k], yv_a[k], sd_a[k], cs_a[k]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sd_a[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width: got %b required 0", sd_a[0]);
    end
  endtask

  task automatic test_retarget();
    int lows, pulses;
    sel_a[0] = 2'd0;
    repeat (5) @(negedge clk);
    sel_a[0] = 2'd1;
    lows = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (yv_a[0] == 1'b0) lows++;
      if (sd_a[0] == 1'b1) pulses++;
      if (c == 1) sel_a[0] = 2'd3;
    end
    n_cmp++;
    if (lows !== 5 || pulses !== 1) begin
      n_bad++;
      $display("FAIL retarget_count: got low=%0d pulses=%0d required 5 1", lows, pulses);
    end
    n_cmp++;
    if ({y_a[0], cs_a[0]} !== {8'h44, 2'd3}) begin
      n_bad++;
      $display("FAIL retarget_final: got y=%h cs=%0d required 44 3", y_a[0], cs_a[0]);
    end
  endtask

  task automatic test_invalid();
    sel_a[2] = 2'd3;
    @(negedge clk);
    n_cmp++;
    if ({se_a[2], cs_a[2], yv_a[2], y_a[2]} !== {1'b1, 2'd0, 1'b1, 8'hAA}) begin
      n_bad++;
      $display("FAIL invalid_lock: got err=%b cs=%0d v=%b y=%h required 1 0 1 aa",
               se_a[2], cs_a[2], yv_a[2], y_a[2]);
    end
    sel_a[2] = 2'd1;
    @(negedge clk);
    n_cmp++;
    if ({se_a[2], yv_a[2]} !== 2'b00) begin
      n_bad++;
      $display("FAIL invalid_clear: got err=%b v=%b required 0 0", se_a[2], yv_a[2]);
    end
    sel_a[2] = 2'd3;
    @(negedge clk);
    n_cmp++;
    if ({se_a[2], yv_a[2]} !== 2'b10) begin
      n_bad++;
      $display("FAIL invalid_blank: got err=%b v=%b required 1 0", se_a[2], yv_a[2]);
    end
    @(negedge clk);
    n_cmp++;
    if ({cs_a[2], yv_a[2], sd_a[2], se_a[2], y_a[2]} !== {2'd1, 1'b1, 1'b1, 1'b1, 8'hBB}) begin
      n_bad++;
      $display("FAIL invalid_complete: got cs=%0d v=%b d=%b err=%b y=%h required 1 1 1 1 bb",
               cs_a[2], yv_a[2], sd_a[2], se_a[2], y_a[2]);
    end
    sel_a[2] = 2'd1;
    @(negedge clk);
  endtask

  task automatic test_b0_toggle();
    logic [31:0] ti;
    logic [7:0]  exp_y;
    int          s, prev;
    prev = int'(sel_a[3]);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j > 0) begin
        n_cmp++;
        if ({y_a[3], yv_a[3], sd_a[3], cs_a[3]} !== {exp_y, 1'b1, 1'b1, 2'(prev)}) begin
          n_bad++;
          $display("FAIL b0_toggle[%0d]: got y=%h v=%b d=%b cs=%0d required %h 1 1 %0d",
                   j, y_a[3], yv_a[3], sd_a[3], cs_a[3], exp_y, prev);
        end
      end
      s  = (prev + 1 + int'($urandom_range(0, 2))) % 4;
      ti = $urandom;
      exp_y = ti[s*8 +: 8];
      i_a[3]   = ti;
      sel_a[3] = 2'(s);
      prev = s;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        got = {y_a[k], yv_a[k], cs_a[k], sd_a[k], se_a[k]};
        exp = {m_y[k], m_v[k], 2'(m_cur[k]), m_done[k], m_err[k]};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL random[%0d] inst%0d: got %h required %h (y,v,cs,done,err)",
                   j, k, got, exp);
        end
      end
      for (int k = 0; k < 4; k++) begin
        i_a[k] = (k == 2) ? {8'h00, 24'($urandom)} : $urandom;
        if ($urandom_range(0, 4) == 0) sel_a[k] = 2'($urandom_range(0, 3));
      end
      if (j == 300) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_hold();
    test_retarget();
    test_invalid();
    test_b0_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mux_n.md
# seq_mux_n

Parametrised, registered N-channel multiplexer with guarded select switching. It is the clocked successor to the combinational 2:1 mux and is generalised in data width and channel count. On every select change the output is blanked for a programmable number of cycles before the new channel is delivered, so downstream logic never sees a mid-switch mix of channels. It sits between parallel data sources and a single consumer.

## Interface
Parameters:
- `N`, 4: channel count, ≥ 2.
- `WIDTH`, 8: data width per channel, ≥ 1.
- `BLANK_CYC`, 3: number of blanking cycles on a switch, ≥ 0.
- `HOLD_MODE`, 1: behaviour of `y` during blanking. 1 holds the last value; 0 drives all-zero.
- Derived localparam `SELW` = max(1, clog2(N)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `i` in N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `sel` in SELW: requested channel, sampled every cycle.
- `y` out WIDTH: registered output.
- `y_valid` out 1: high when `y` carries live data from `cur_sel`.
- `cur_sel` out SELW: the channel currently delivered.
- `switch_done` out 1: one-cycle pulse when a switch completes.
- `sel_err` out 1: registered; high when `sel` ≥ N was sampled.

## Operation
- State machine states:
  - LOCK: delivering `cur_sel`.
  - BLANK: counting down towards target `tgt`.
- Reset values: state=LOCK, `cur_sel`=0, `tgt`=0, `cnt`=0, `y`=0, `y_valid`=0, `switch_done`=0, `sel_err`=0.
- A select value is valid when `sel` < N. An invalid `sel` is ignored for switching and only sets `sel_err`=1 on the next edge. `sel_err` clears on the first edge that samples a valid `sel`.
- LOCK, valid `sel` == `cur_sel`:
  - `y` ← i[cur_sel], `y_valid` ← 1.
- LOCK, valid `sel` ≠ `cur_sel`, BLANK_CYC > 0:
  - Next state BLANK; `tgt` ← sel, `cnt` ← BLANK_CYC−1, `y_valid` ← 0.
  - `y` ← hold (HOLD_MODE=1) or 0 (HOLD_MODE=0).
- LOCK, valid `sel` ≠ `cur_sel`, BLANK_CYC = 0:
  - Same edge: `cur_sel` ← sel, `y` ← i[sel], `y_valid` stays 1, `switch_done` ← 1.
- BLANK, valid `sel` ≠ `tgt`:
  - Retarget: `tgt` ← sel, `cnt` ← BLANK_CYC−1, full blanking restarts.
  - This includes `sel` returning to the old `cur_sel`.
- BLANK, `cnt` > 0 (no retarget): `cnt` decrements; `y` per HOLD_MODE.
- BLANK, `cnt` = 0 (no retarget):
  - Next state LOCK; `cur_sel` ← tgt, `y` ← i[tgt], `y_valid` ← 1, `switch_done` ← 1.
- An invalid `sel` during BLANK does not disturb the countdown towards `tgt`.
- `switch_done` is high for exactly one cycle per completed switch. It is never asserted while in reset.

## Timing
- Data latency in LOCK: 1 cycle, i.e. `y`(t+1) = i[cur_sel](t).
- Switch latency, BLANK_CYC = B > 0:
  - The new `sel` is sampled at edge t.
  - `y_valid` is low for B cycles, starting with the cycle after edge t.
  - At edge t+B, `y` = i[new], `y_valid` = 1, `switch_done` = 1.
- Switch latency, BLANK_CYC = 0: 1 cycle, with no `y_valid` gap.
- `rst_n` low at any point, including mid-BLANK: all outputs go to their reset values immediately, asynchronously.
- After `rst_n` deasserts:
  - The first edge behaves as LOCK with `cur_sel` = 0.
  - If `sel` ≠ 0 at that edge, blanking starts and `y_valid` stays 0.

## Structure
- Shared package `mux_pkg`:
  - state enum {LOCK, BLANK};
  - `clog2_min1` function for SELW.
- Sub-module `blank_timer`: loadable down-counter of width clog2(BLANK_CYC+1), with `load`, `zero` and `busy` signals. It is instantiated only when BLANK_CYC > 0 (generate).
- Channel select is an indexed part-select on the flat bus. No per-channel logic.

## Test plan
- Reset and steady state:
  - Stimulus: N=4, WIDTH=8, i={8'h44,8'h33,8'h22,8'h11}, sel=0, release `rst_n`.
  - Required: after 1 edge `y`=8'h11 and `y_valid`=1. Assert `rst_n` mid-stream: `y`=0 immediately.
- Switch 0→2, B=3, HOLD_MODE=1:
  - Required: `y_valid` low for 3 cycles while `y` holds 8'h11.
  - Then `y`=8'h33 with a one-cycle `switch_done`, and `cur_sel`=2.
- HOLD_MODE=0, same switch:
  - Required: `y`=8'h00 during the 3 blank cycles, then 8'h33.
- Retarget mid-blank:
  - Stimulus: sel 0→1, then 2 cycles later sel→3.
  - Required: blanking restarts; `y_valid` low for 2+3 cycles total.
  - Final `y`=8'h44 with a single `switch_done` pulse.
- Invalid select:
  - Stimulus: N=3, sel=3 in LOCK and during BLANK.
  - Required: `sel_err`=1 on the next cycle; `cur_sel` unchanged; an in-progress blank still completes to its target.
- B=0 with a select toggling every cycle:
  - Required: `y` follows i[sel] with 1-cycle latency.
  - `y_valid` stays 1 and `switch_done` pulses on every change.
